// File: rtl/ecc_scrub_ctrl_if.sv
// Memory-side bus of the ECC scrubber: request/acknowledge handshake plus
// read and write-back data paths. The scrubber is master, the memory is slave.
interface ecc_scrub_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [6:0]        mem_wpar;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [6:0]        mem_rpar;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wpar,
    input  mem_ack, mem_rdata, mem_rpar
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wpar,
    output mem_ack, mem_rdata, mem_rpar
  );
endinterface

// File: rtl/ecc_scrub_ctrl.sv
// ECC scrub controller: sweeps addresses 0..LAST_ADDR, corrects single errors
// by write-back and logs double errors. Define ECC_SCRUB_DED_STOP_EN to stop the sweep on a double error.
module ecc_scrub_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int LAST_ADDR = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  ecc_scrub_ctrl_if.master  mem,
  output logic [31:0]       chk_data_o,
  output logic [6:0]        chk_parity_o,
  input  logic [31:0]       chk_corr_data_i,
  input  logic [5:0]        chk_corr_par_i,
  input  logic              chk_single_i,
  input  logic              chk_double_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       sec_count_o,
  output logic [15:0]       ded_count_o,
  output logic [ADDR_W-1:0] ded_addr_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] NEXT  = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  logic [2:0]        state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              abortPend_q, abortPend_d;
  logic [15:0]       secCount_q,  secCount_d;
  logic [15:0]       dedCount_q,  dedCount_d;
  logic [ADDR_W-1:0] dedAddr_q,   dedAddr_d;
  logic [31:0]       chkData_q,   chkData_d;
  logic [6:0]        chkPar_q,    chkPar_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [6:0]        wpar_q,      wpar_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    abortPend_d = abortPend_q;
    secCount_d  = secCount_q;
    dedCount_d  = dedCount_q;
    dedAddr_d   = dedAddr_q;
    chkData_d   = chkData_q;
    chkPar_d    = chkPar_q;
    wdata_d     = wdata_q;
    wpar_d      = wpar_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = READ;
          addr_d      = '0;
          secCount_d  = '0;
          dedCount_d  = '0;
          abortPend_d = 1'b0;
        end
      end
      READ: begin
        if (abort_i) begin
          state_d = FIN;
        end else if (mem.mem_ack) begin
          chkData_d = mem.mem_rdata;
          chkPar_d  = mem.mem_rpar;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        // Double errors dominate; they are logged even if an abort arrives now.
        if (chk_double_i) begin
          dedCount_d = (dedCount_q == 16'hFFFF) ? dedCount_q : dedCount_q + 16'd1;
          dedAddr_d  = addr_q;
`ifdef ECC_SCRUB_DED_STOP_EN
          state_d    = FIN;
`else
          state_d    = NEXT;
`endif
        end else if (chk_single_i) begin
          secCount_d = (secCount_q == 16'hFFFF) ? secCount_q : secCount_q + 16'd1;
          wdata_d    = chk_corr_data_i;
          wpar_d     = {^{chk_corr_data_i, chk_corr_par_i}, chk_corr_par_i};
          state_d    = WRITE;
        end else begin
          state_d    = NEXT;
        end
        if (abort_i) begin
          state_d = FIN;
        end
      end
      WRITE: begin
        if (abort_i) begin
          abortPend_d = 1'b1;
        end
        if (mem.mem_ack) begin
          state_d = (abortPend_q || abort_i) ? FIN : NEXT;
        end
      end
      NEXT: begin
        if (abort_i || addr_q == LAST) begin
          state_d = FIN;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = READ;
        end
      end
      FIN: begin
        abortPend_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      abortPend_q <= 1'b0;
      secCount_q  <= '0;
      dedCount_q  <= '0;
      dedAddr_q   <= '0;
      chkData_q   <= '0;
      chkPar_q    <= '0;
      wdata_q     <= '0;
      wpar_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      abortPend_q <= abortPend_d;
      secCount_q  <= secCount_d;
      dedCount_q  <= dedCount_d;
      dedAddr_q   <= dedAddr_d;
      chkData_q   <= chkData_d;
      chkPar_q    <= chkPar_d;
      wdata_q     <= wdata_d;
      wpar_q      <= wpar_d;
    end
  end

  assign mem.mem_req   = (state_q == READ) || (state_q == WRITE);
  assign mem.mem_we    = (state_q == WRITE);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wpar  = wpar_q;

  assign chk_data_o   = chkData_q;
  assign chk_parity_o = chkPar_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == FIN);
  assign sec_count_o  = secCount_q;
  assign ded_count_o  = dedCount_q;
  assign ded_addr_o   = dedAddr_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Self-checking bench for ecc_scrub_ctrl with LAST_ADDR=3: a memory responder,
// a table-driven checker model and a sweep-level reference model.
module tb_ecc_scrub_ctrl;
  localparam int LAST = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] chk_data;
  logic [6:0]  chk_parity;
  logic [31:0] chk_corr_data;
  logic [5:0]  chk_corr_par;
  logic        chk_single;
  logic        chk_double;
  logic        busy;
  logic        done;
  logic [15:0] sec_count;
  logic [15:0] ded_count;
  logic [7:0]  ded_addr;

  ecc_scrub_ctrl_if #(.ADDR_W(8)) mem ();

  ecc_scrub_ctrl #(.ADDR_W(8), .LAST_ADDR(LAST)) dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .mem(mem),
    .chk_data_o(chk_data), .chk_parity_o(chk_parity),
    .chk_corr_data_i(chk_corr_data), .chk_corr_par_i(chk_corr_par),
    .chk_single_i(chk_single), .chk_double_i(chk_double),
    .busy_o(busy), .done_o(done), .sec_count_o(sec_count),
    .ded_count_o(ded_count), .ded_addr_o(ded_addr)
  );

  // Memory image: original words, stored (possibly corrupted) words, error kind per address.
  logic [31:0] origData [LAST+1];
  logic [5:0]  origPar  [LAST+1];
  logic [31:0] storData [LAST+1];
  logic [6:0]  storPar  [LAST+1];
  int          errKind  [LAST+1];

  logic [1:0] ci;
  assign ci            = mem.mem_addr[1:0];
  assign chk_single    = (errKind[ci] == 1);
  assign chk_double    = (errKind[ci] == 2);
  assign chk_corr_data = origData[ci];
  assign chk_corr_par  = origPar[ci];

  int          total = 0;
  int          bad = 0;
  int          ackDelay = 1;
  int          donePulses;
  bit          timedOut;
  int          rdAddrQ [$];
  int          wrAddrQ [$];
  logic [31:0] wrDataQ [$];
  logic [6:0]  wrParQ  [$];
  logic [31:0] lastRdData;
  logic [6:0]  lastRdPar;
  int          expRd [$];
  int          expWrA [$];
  logic [31:0] expWrD [$];
  logic [6:0]  expWrP [$];
  int          expSec;
  int          expDed;
  int          expDedAddr = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: acks after ackDelay request cycles, logs every completed access.
  initial begin
    int cnt;
    cnt = 0;
    mem.mem_ack = 1'b0;
    mem.mem_rdata = '0;
    mem.mem_rpar = '0;
    forever begin
      @(negedge clk);
      if (mem.mem_ack) begin
        mem.mem_ack = 1'b0;
        cnt = 0;
      end else if (mem.mem_req && !rst) begin
        cnt++;
        if (cnt >= ackDelay) begin
          mem.mem_ack = 1'b1;
          if (mem.mem_we) begin
            wrAddrQ.push_back(int'(mem.mem_addr));
            wrDataQ.push_back(mem.mem_wdata);
            wrParQ.push_back(mem.mem_wpar);
            storData[mem.mem_addr[1:0]] = mem.mem_wdata;
            storPar[mem.mem_addr[1:0]]  = mem.mem_wpar;
          end else begin
            rdAddrQ.push_back(int'(mem.mem_addr));
            mem.mem_rdata = storData[mem.mem_addr[1:0]];
            mem.mem_rpar  = storPar[mem.mem_addr[1:0]];
            lastRdData    = mem.mem_rdata;
            lastRdPar     = mem.mem_rpar;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // kind 0 = clean, 1 = one flipped bit (bitA), 2 = two flipped bits (bitA, bitB).
  task automatic setWord(input int a, input int kind, input int bitA, input int bitB);
    logic [31:0] flip;
    origData[a] = $urandom;
    origPar[a]  = 6'($urandom);
    storPar[a]  = {^{origData[a], origPar[a]}, origPar[a]};
    flip = '0;
    if (kind >= 1) flip[bitA] = 1'b1;
    if (kind == 2) flip[bitB] = 1'b1;
    storData[a] = origData[a] ^ flip;
    errKind[a]  = kind;
  endtask

  task automatic setRandomWord(input int a, input int kind);
    int b1, b2;
    b1 = $urandom_range(0, 31);
    b2 = (b1 + $urandom_range(1, 31)) % 32;
    setWord(a, kind, b1, b2);
  endtask

  // Sweep-level reference: walk addresses in order and apply the scrub rules directly.
  task automatic refModel(input int preload, input bit abortAtWrite);
    expRd.delete(); expWrA.delete(); expWrD.delete(); expWrP.delete();
    expSec = preload;
    expDed = 0;
    for (int a = 0; a <= LAST; a++) begin
      expRd.push_back(a);
      if (errKind[a] == 2) begin
        expDed++;
        expDedAddr = a;
`ifdef ECC_SCRUB_DED_STOP_EN
        break;
`endif
      end else if (errKind[a] == 1) begin
        expSec = (expSec + 1 > 65535) ? 65535 : expSec + 1;
        expWrA.push_back(a);
        expWrD.push_back(origData[a]);
        expWrP.push_back({^{origData[a], origPar[a]}, origPar[a]});
        if (abortAtWrite) break;
      end
    end
  endtask

  task automatic applyStimulus(input int delay, input bit abortInWrite, input bit preload);
    bit sent;
    int tail;
    sent = 0;
    tail = -1;
    ackDelay = delay;
    rdAddrQ.delete(); wrAddrQ.delete(); wrDataQ.delete(); wrParQ.delete();
    donePulses = 0;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (preload) force dut.secCount_q = 16'hFFFD;
    for (int c = 0; c < 600 && tail != 0; c++) begin
      @(negedge clk);
      if (c == 0 && preload) release dut.secCount_q;
      if (done) begin
        donePulses++;
        if (tail < 0) tail = 4;
      end
      if (tail > 0) tail--;
      if (abortInWrite && !sent && mem.mem_req && mem.mem_we) begin
        abort = 1'b1;
        sent = 1;
      end else begin
        abort = 1'b0;
      end
    end
    abort = 1'b0;
    timedOut = (tail != 0);
  endtask

  task automatic checkSweep(input string name);
    checkOutput({name, "_timeout"}, 32'(timedOut), 0);
    checkOutput({name, "_done_pulses"}, donePulses, 1);
    checkOutput({name, "_read_count"}, rdAddrQ.size(), expRd.size());
    for (int i = 0; i < rdAddrQ.size() && i < expRd.size(); i++)
      checkOutput($sformatf("%s_read_addr%0d", name, i), rdAddrQ[i], expRd[i]);
    checkOutput({name, "_write_count"}, wrAddrQ.size(), expWrA.size());
    for (int i = 0; i < wrAddrQ.size() && i < expWrA.size(); i++) begin
      checkOutput($sformatf("%s_write_addr%0d", name, i), wrAddrQ[i], expWrA[i]);
      checkOutput($sformatf("%s_write_data%0d", name, i), wrDataQ[i], expWrD[i]);
      checkOutput($sformatf("%s_write_par%0d", name, i), wrParQ[i], expWrP[i]);
    end
    checkOutput({name, "_sec"}, sec_count, expSec);
    checkOutput({name, "_ded"}, ded_count, expDed);
    checkOutput({name, "_ded_addr"}, ded_addr, expDedAddr);
    checkOutput({name, "_busy"}, busy, 0);
    checkOutput({name, "_chk_data"}, chk_data, lastRdData);
    checkOutput({name, "_chk_parity"}, chk_parity, lastRdPar);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int a = 0; a <= LAST; a++) setWord(a, 0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_req", mem.mem_req, 0);
    checkOutput("rst_we", mem.mem_we, 0);
    checkOutput("rst_sec", sec_count, 0);
    checkOutput("rst_ded", ded_count, 0);
    checkOutput("rst_ded_addr", ded_addr, 0);
    checkOutput("rst_chk_data", chk_data, 0);
    checkOutput("rst_chk_parity", chk_parity, 0);
    checkOutput("rst_wdata", mem.mem_wdata, 0);
    checkOutput("rst_wpar", mem.mem_wpar, 0);
    rst = 1'b0;

    // All words clean.
    for (int a = 0; a <= LAST; a++) setWord(a, 0, 0, 0);
    refModel(0, 0);
    applyStimulus(1, 0, 0);
    checkSweep("clean");

    // Data bit 5 flipped at address 2.
    setWord(2, 1, 5, 0);
    refModel(0, 0);
    applyStimulus(1, 0, 0);
    checkSweep("single");
    checkOutput("single_mem_fixed", storData[2], origData[2]);

    // Two bits flipped at address 1.
    for (int a = 0; a <= LAST; a++) setWord(a, 0, 0, 0);
    setWord(1, 2, 3, 17);
    refModel(0, 0);
    applyStimulus(1, 0, 0);
    checkSweep("double");
`ifdef ECC_SCRUB_DED_STOP_EN
    checkOutput("double_stop_reads", rdAddrQ.size(), 2);
`else
    checkOutput("double_stop_reads", rdAddrQ.size(), 4);
`endif

    // Random error patterns and ack latencies.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a <= LAST; a++) setRandomWord(a, $urandom_range(0, 2));
      refModel(0, 0);
      applyStimulus($urandom_range(1, 3), 0, 0);
      checkSweep($sformatf("rand%0d", r));
    end

    // Abort during a write whose ack is 3 cycles late.
    for (int a = 0; a <= LAST; a++) setWord(a, 0, 0, 0);
    setRandomWord(1, 1);
    refModel(0, 1);
    applyStimulus(3, 1, 0);
    checkSweep("abort_write");

    // Saturation: counter preloaded near the top, then four more corrections.
    for (int a = 0; a <= LAST; a++) setRandomWord(a, 1);
    refModel(65533, 0);
    applyStimulus(1, 0, 1);
    checkSweep("saturate");

    // Abort while a slow read of address 1 is outstanding.
    for (int a = 0; a <= LAST; a++) setWord(a, 0, 0, 0);
    rdAddrQ.delete();
    ackDelay = 5;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (mem.mem_req && !mem.mem_we && mem.mem_addr == 8'd1) found = 1;
    end
    checkOutput("abort_read_reach", 32'(found), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_read_done", done, 1);
    checkOutput("abort_read_req", mem.mem_req, 0);
    @(negedge clk);
    checkOutput("abort_read_idle", busy, 0);
    checkOutput("abort_read_reads", rdAddrQ.size(), 1);

    // Reset in READ after one correction has been counted.
    setRandomWord(0, 1);
    ackDelay = 5;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (mem.mem_req && !mem.mem_we && mem.mem_addr == 8'd1) found = 1;
    end
    checkOutput("rst_mid_reach", 32'(found), 1);
    checkOutput("rst_mid_sec_before", sec_count, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_req", mem.mem_req, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_sec", sec_count, 0);
    checkOutput("rst_mid_ded", ded_count, 0);
    checkOutput("rst_mid_ded_addr", ded_addr, 0);
    rst = 1'b0;
    donePulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) donePulses++;
      @(negedge clk);
    end
    checkOutput("rst_mid_no_done", donePulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
